// File: rtl/bcd_seven_segment_scanner_pkg.sv
// Shared types and constants for the multiplexed BCD seven-segment scanner.
package bcd_seven_segment_scanner_pkg;

  localparam int BCD_NIBBLE = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_seven_segment_scanner_bcd_to_seven_segment.sv
// Combinational BCD nibble to active-high seven-segment pattern.
// Nibbles above 9 are not decimal digits and are shown as a dash.
module bcd_to_seven_segment
  import bcd_seven_segment_scanner_pkg::*;
(
  input  logic [BCD_NIBBLE-1:0] nibble_i,
  output logic [6:0]            seg_o
);

  // Decode table; the default arm covers every illegal nibble.
  always_comb begin
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seven_segment_scanner.sv
// Multiplexed common-anode display scanner. Cycles BLANK/SHOW per digit,
// double-buffers incoming BCD so a frame is never torn, suppresses leading
// zeros and applies output polarity before the output registers.
module bcd_seven_segment_scanner
  import bcd_seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS         = 3,
  parameter int PRESCALE           = 12000,
  parameter int BLANK_CYCLES       = 16,
  parameter bit ANODE_ACTIVE_LOW   = 1'b1,
  parameter bit SEGMENT_ACTIVE_LOW = 1'b1,
  parameter bit LEADING_ZERO_BLANK = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [BCD_NIBBLE*NUM_DIGITS-1:0] bcd_in,
  input  logic                             bcd_valid,
  output logic                             bcd_accepted,
  output logic                             frame_start,
  output logic [NUM_DIGITS-1:0]            anode,
  output logic [6:0]                       segment
);

  localparam int BCD_W   = BCD_NIBBLE * NUM_DIGITS;
  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Inactive output levels; XOR-ing an active-high value with these applies polarity.
  localparam logic [NUM_DIGITS-1:0] ANODE_IDLE = ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [6:0]            SEG_IDLE   = SEGMENT_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  state_e                state_q, state_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BCD_W-1:0]      displayed_q, displayed_d;
  logic [BCD_W-1:0]      pending_q, pending_d;
  logic                  pending_flag_q, pending_flag_d;
  logic                  bcd_accepted_q, bcd_accepted_d;
  logic                  frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            segment_q, segment_d;

  logic                  boundary;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [BCD_NIBBLE-1:0] cur_nibble;
  logic [6:0]            cur_pattern;
  logic                  lit;

  // Scan FSM, dwell counter and double buffer next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    digit_d        = digit_q;
    cnt_d          = cnt_q + CNT_W'(1);
    displayed_d    = displayed_q;
    pending_d      = pending_q;
    pending_flag_d = pending_flag_q;
    bcd_accepted_d = 1'b0;
    boundary       = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          state_d  = ST_SHOW;
          cnt_d    = '0;
          boundary = (digit_q == '0);
        end
      end
      ST_SHOW: begin
        if (cnt_q == CNT_W'(PRESCALE - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          digit_d = (digit_q == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DIGIT_W'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // A strobe on the boundary itself bypasses the pending buffer.
    if (boundary && (pending_flag_q || bcd_valid)) begin
      displayed_d    = bcd_valid ? bcd_in : pending_q;
      pending_flag_d = 1'b0;
      bcd_accepted_d = 1'b1;
    end else if (bcd_valid) begin
      pending_d      = bcd_in;
      pending_flag_d = 1'b1;
    end

    frame_start_d = boundary;
  end

  // Digit k >= 1 is blanked when it and every more significant digit are zero.
  always_comb begin
    blank_mask = '0;
    if (LEADING_ZERO_BLANK) begin
      for (int k = 1; k < NUM_DIGITS; k++) begin
        blank_mask[k] = ((displayed_d >> (k * BCD_NIBBLE)) == '0);
      end
    end
  end

  assign cur_nibble = displayed_d[digit_d * BCD_NIBBLE +: BCD_NIBBLE];

  bcd_to_seven_segment u_decode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_pattern)
  );

  // Output values are derived from next state so registered outputs line up with the FSM state.
  always_comb begin
    lit       = (state_d == ST_SHOW) && !blank_mask[digit_d];
    anode_d   = (lit ? (NUM_DIGITS'(1) << digit_d) : '0) ^ ANODE_IDLE;
    segment_d = (lit ? cur_pattern : SEG_OFF) ^ SEG_IDLE;
  end

  // State, buffers and output registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the buffers are plain registers, not memories, so resetting them is cheap and makes discard-on-reset exact.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_BLANK;
      digit_q        <= '0;
      cnt_q          <= '0;
      displayed_q    <= '0;
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      bcd_accepted_q <= 1'b0;
      frame_start_q  <= 1'b0;
      anode_q        <= ANODE_IDLE;
      segment_q      <= SEG_IDLE;
    end else begin
      state_q        <= state_d;
      digit_q        <= digit_d;
      cnt_q          <= cnt_d;
      displayed_q    <= displayed_d;
      pending_q      <= pending_d;
      pending_flag_q <= pending_flag_d;
      bcd_accepted_q <= bcd_accepted_d;
      frame_start_q  <= frame_start_d;
      anode_q        <= anode_d;
      segment_q      <= segment_d;
    end
  end

  assign bcd_accepted = bcd_accepted_q;
  assign frame_start  = frame_start_q;
  assign anode        = anode_q;
  assign segment      = segment_q;

endmodule

// File: tb/tb_bcd_seven_segment_scanner.sv
// Directed bench for the scanner: 3 digits, 8-cycle dwell, 2-cycle blank, active-low outputs.
module tb_bcd_seven_segment_scanner;

  localparam int ND    = 3;
  localparam int PRE   = 8;
  localparam int BLK   = 2;
  localparam int SLOT  = PRE + BLK;
  localparam int FRAME = ND * SLOT;

  // Expected active-low segment patterns.
  localparam logic [6:0] S_OFF  = 7'b1111111;
  localparam logic [6:0] S_0    = 7'b1000000;
  localparam logic [6:0] S_2    = 7'b0100100;
  localparam logic [6:0] S_4    = 7'b0011001;
  localparam logic [6:0] S_5    = 7'b0010010;
  localparam logic [6:0] S_6    = 7'b0000010;
  localparam logic [6:0] S_7    = 7'b1111000;
  localparam logic [6:0] S_DASH = 7'b0111111;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [11:0]   bcd_in = '0;
  logic          bcd_valid = 1'b0;
  logic          bcd_accepted;
  logic          frame_start;
  logic [ND-1:0] anode;
  logic [6:0]    segment;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_seven_segment_scanner #(
    .NUM_DIGITS         (ND),
    .PRESCALE           (PRE),
    .BLANK_CYCLES       (BLK),
    .ANODE_ACTIVE_LOW   (1'b1),
    .SEGMENT_ACTIVE_LOW (1'b1),
    .LEADING_ZERO_BLANK (1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bcd_in       (bcd_in),
    .bcd_valid    (bcd_valid),
    .bcd_accepted (bcd_accepted),
    .frame_start  (frame_start),
    .anode        (anode),
    .segment      (segment)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Steps one full frame starting with the edge that enters SHOW of digit 0.
  // lit[d] says whether digit d's anode should ever be active this frame.
  // Up to two bcd_valid strobes are sampled at frame offsets off1/off2 (-1 = none).
  task automatic check_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [2:0] lit, input logic acc_at_0,
                             input int off1, input logic [11:0] v1,
                             input int off2, input logic [11:0] v2);
    logic [6:0]    segs [ND];
    logic [ND-1:0] exp_an;
    logic [6:0]    exp_sg;
    int            d;
    segs[0] = s0;
    segs[1] = s1;
    segs[2] = s2;
    for (int o = 0; o < FRAME; o++) begin
      if (o == off1) begin bcd_in = v1; bcd_valid = 1'b1; end
      if (o == off2) begin bcd_in = v2; bcd_valid = 1'b1; end
      tick();
      bcd_valid = 1'b0;
      d = o / SLOT;
      if ((o % SLOT) < PRE && lit[d]) begin
        exp_an = ~(ND'(1) << d);
        exp_sg = segs[d];
      end else begin
        exp_an = '1;
        exp_sg = S_OFF;
      end
      check($sformatf("%s anode o=%0d", tag, o), 32'(anode), 32'(exp_an));
      check($sformatf("%s segment o=%0d", tag, o), 32'(segment), 32'(exp_sg));
      check($sformatf("%s frame_start o=%0d", tag, o), 32'(frame_start), 32'(o == 0));
      check($sformatf("%s accepted o=%0d", tag, o), 32'(bcd_accepted), 32'((o == 0) && acc_at_0));
    end
  endtask

  initial begin
    // Reset state while held.
    #12;
    check("reset anode", 32'(anode), 32'h7);
    check("reset segment", 32'(segment), 32'(S_OFF));
    check("reset frame_start", 32'(frame_start), 32'd0);
    check("reset accepted", 32'(bcd_accepted), 32'd0);

    // 1: release; first edge still blank, digit 0 enters SHOW on the second edge.
    #10 reset = 1'b1;
    tick();
    check("t1 blank anode", 32'(anode), 32'h7);
    check("t1 blank segment", 32'(segment), 32'(S_OFF));
    check_frame("t1", S_0, S_OFF, S_OFF, 3'b001, 1'b0, -1, '0, -1, '0);

    // 2: 042 mid-frame is held until the next boundary.
    check_frame("t2a", S_0, S_OFF, S_OFF, 3'b001, 1'b0, 5, 12'h042, -1, '0);
    // 3: load 000 during the 042 frame.
    check_frame("t2b", S_2, S_4, S_OFF, 3'b011, 1'b1, 12, 12'h000, -1, '0);
    // 4: 123 then 456 three cycles later, same frame; newest wins.
    check_frame("t3", S_0, S_OFF, S_OFF, 3'b001, 1'b1, 4, 12'h123, 7, 12'h456);
    check_frame("t4", S_6, S_5, S_4, 3'b111, 1'b1, -1, '0, -1, '0);
    // 5: 0B7 strobed exactly on the boundary is shown in that same frame.
    check_frame("t5", S_7, S_DASH, S_OFF, 3'b011, 1'b1, 0, 12'h0B7, -1, '0);

    // 6: a pending value, then reset during SHOW of digit 1.
    for (int i = 0; i < SLOT + 3; i++) begin
      if (i == 2) begin bcd_in = 12'h999; bcd_valid = 1'b1; end
      tick();
      bcd_valid = 1'b0;
    end
    check("t6 digit1 anode", 32'(anode), 32'h5);
    check("t6 digit1 segment", 32'(segment), 32'(S_DASH));
    #2 reset = 1'b0;
    #1;
    check("t6 async anode", 32'(anode), 32'h7);
    check("t6 async segment", 32'(segment), 32'(S_OFF));
    tick();
    reset = 1'b1;
    tick();
    check("t6 blank anode", 32'(anode), 32'h7);
    check_frame("t6", S_0, S_OFF, S_OFF, 3'b001, 1'b0, -1, '0, -1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
